// File: rtl/dcache_2way_ctrl_if.sv
// CPU (MEM stage) and line-wide memory bus bundle for dcache_2way_ctrl.
// slave = cache side, master = pipeline/memory side.
interface dcache_2way_ctrl_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_BITS = 256
) ();
  logic [ADDR_W-1:0]    p1_addr_i;
  logic [31:0]          p1_data_i;
  logic                 p1_MemRead_i;
  logic                 p1_MemWrite_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative write-back, write-allocate data cache controller with LRU replacement.
// Optional DCACHE_PERF_CNT_EN adds saturating hit/miss/write-back counters.
module dcache_2way_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned SET_BITS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dcache_2way_ctrl_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  localparam int unsigned OFF    = $clog2(LINE_BITS / 8);
  localparam int unsigned TAG_W  = ADDR_W - SET_BITS - OFF;
  localparam int unsigned SETS   = 1 << SET_BITS;
  localparam int unsigned WSEL_W = OFF - 2;

  typedef enum logic [1:0] {StIdle, StWriteback, StGap, StRefill} state_e;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [SET_BITS-1:0]  idx_t;
  typedef logic [LINE_BITS-1:0] line_t;

  state_e                  state_q, state_d;
  tag_t                    tag_q [SETS][2];
  tag_t                    tag_d [SETS][2];
  logic [SETS-1:0][1:0]    valid_q, valid_d;
  logic [SETS-1:0][1:0]    dirty_q, dirty_d;
  logic [SETS-1:0]         lru_q, lru_d;
  line_t                   data_q [SETS][2];
  idx_t                    miss_idx_q, miss_idx_d;
  tag_t                    miss_tag_q, miss_tag_d;
  logic                    victim_q, victim_d;
  logic                    refill_done_q, refill_done_d;
  logic                    mem_enable_q, mem_enable_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  line_t                   mem_data_q, mem_data_d;

  logic                    req, store;
  idx_t                    idx;
  tag_t                    tag;
  logic [WSEL_W-1:0]       wsel;
  logic [1:0]              match;
  logic                    hit, hit_way, victim;
  line_t                   hit_line, merged_line;
  logic                    data_we, data_wway;
  idx_t                    data_widx;
  line_t                   data_wline;
  logic [1:0]              unused_addr;

  assign req         = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  // A simultaneous read+write request is a store.
  assign store       = bus.p1_MemWrite_i;
  assign idx         = bus.p1_addr_i[OFF +: SET_BITS];
  assign tag         = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel        = bus.p1_addr_i[2 +: WSEL_W];
  assign unused_addr = bus.p1_addr_i[1:0];

  assign match[0] = valid_q[idx][0] & (tag_q[idx][0] == tag);
  assign match[1] = valid_q[idx][1] & (tag_q[idx][1] == tag);
  assign hit_way  = ~match[0];
  assign hit      = req & (state_q == StIdle) & (|match);
  assign hit_line = data_q[idx][hit_way];
  assign victim   = ~valid_q[idx][0] ? 1'b0 :
                    ~valid_q[idx][1] ? 1'b1 : lru_q[idx];

  always_comb begin
    merged_line = hit_line;
    merged_line[32*wsel +: 32] = bus.p1_data_i;
  end

  assign bus.p1_data_o    = hit ? hit_line[32*wsel +: 32] : 32'h0;
  assign bus.p1_stall_o   = req & ~hit;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    lru_d         = lru_q;
    miss_idx_d    = miss_idx_q;
    miss_tag_d    = miss_tag_q;
    victim_d      = victim_q;
    refill_done_d = 1'b0;
    mem_enable_d  = mem_enable_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    data_we       = 1'b0;
    data_widx     = idx;
    data_wway     = hit_way;
    data_wline    = merged_line;

    unique case (state_q)
      StIdle: begin
        if (hit) begin
          lru_d[idx] = ~hit_way;
          if (store) begin
            dirty_d[idx][hit_way] = 1'b1;
            data_we               = 1'b1;
          end
        end else if (req) begin
          miss_idx_d   = idx;
          miss_tag_d   = tag;
          victim_d     = victim;
          mem_enable_d = 1'b1;
          if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
            state_d     = StWriteback;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx][victim], idx, {OFF{1'b0}}};
            mem_data_d  = data_q[idx][victim];
          end else begin
            state_d     = StRefill;
            mem_write_d = 1'b0;
            mem_addr_d  = {tag, idx, {OFF{1'b0}}};
          end
        end
      end
      StWriteback: begin
        if (bus.mem_ack_i) begin
          state_d      = StGap;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
        end
      end
      StGap: begin
        state_d      = StRefill;
        mem_enable_d = 1'b1;
        mem_write_d  = 1'b0;
        mem_addr_d   = {miss_tag_q, miss_idx_q, {OFF{1'b0}}};
      end
      StRefill: begin
        if (bus.mem_ack_i) begin
          state_d                         = StIdle;
          mem_enable_d                    = 1'b0;
          data_we                         = 1'b1;
          data_widx                       = miss_idx_q;
          data_wway                       = victim_q;
          data_wline                      = bus.mem_data_i;
          valid_d[miss_idx_q][victim_q]   = 1'b1;
          dirty_d[miss_idx_q][victim_q]   = 1'b0;
          tag_d[miss_idx_q][victim_q]     = miss_tag_q;
          lru_d[miss_idx_q]               = ~victim_q;
          refill_done_d                   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= StIdle;
      tag_q         <= '{default: '0};
      valid_q       <= '0;
      dirty_q       <= '0;
      lru_q         <= '0;
      miss_idx_q    <= '0;
      miss_tag_q    <= '0;
      victim_q      <= 1'b0;
      refill_done_q <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      lru_q         <= lru_d;
      miss_idx_q    <= miss_idx_d;
      miss_tag_q    <= miss_tag_d;
      victim_q      <= victim_d;
      refill_done_q <= refill_done_d;
      mem_enable_q  <= mem_enable_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
    end
  end

  // Line storage needs no reset: valid bits gate every read.
  always_ff @(posedge clk_i) begin
    if (data_we) begin
      data_q[data_widx][data_wway] <= data_wline;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    // The hit that completes a miss is not a fresh hit.
    if (hit && !refill_done_q && hit_cnt_q != 32'hFFFF_FFFF) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (state_q == StIdle && state_d != StIdle && miss_cnt_q != 32'hFFFF_FFFF) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if (state_q == StWriteback && bus.mem_ack_i && wb_cnt_q != 32'hFFFF_FFFF) begin
      wb_cnt_d = wb_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Bench for dcache_2way_ctrl: directed scenarios then random traffic against a
// set/way/recency model of the cache and a sparse line-addressed memory model.
`timescale 1ns/1ps
module tb_dcache_2way_ctrl;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned SET_BITS  = 4;
  localparam int unsigned SETS      = 16;
  localparam int unsigned WORDS     = 8;
  localparam int unsigned LAT       = 10;

  typedef logic [LINE_BITS-1:0] line_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  dcache_2way_ctrl_if #(.ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS)) bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  dcache_2way_ctrl #(
    .ADDR_W   (ADDR_W),
    .LINE_BITS(LINE_BITS),
    .SET_BITS (SET_BITS)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt),
    .wb_cnt_o  (wb_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Reference state
  bit          m_valid [SETS][2];
  bit          m_dirty [SETS][2];
  int unsigned m_tag   [SETS][2];
  line_t       m_line  [SETS][2];
  int          m_mru   [SETS];
  line_t       mem_model [int unsigned];
  int          m_hits, m_misses, m_wbs;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic line_t mem_read(input int unsigned la);
    line_t r;
    if (mem_model.exists(la)) return mem_model[la];
    for (int w = 0; w < int'(WORDS); w++) begin
      r[32*w +: 32] = (la * 32'h9E37_79B9) ^ (w * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < int'(SETS); s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      m_mru[s] = 1;
    end
    m_hits = 0;
    m_misses = 0;
    m_wbs = 0;
  endtask

  task automatic clear_inputs();
    bus.p1_addr_i     = '0;
    bus.p1_data_i     = '0;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
    bus.mem_ack_i     = 1'b0;
    bus.mem_data_i    = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_enable", bus.mem_enable_o, 0);
    check_eq("rst_write", bus.mem_write_o, 0);
    check_eq("rst_addr", bus.mem_addr_o, 0);
    check_eq("rst_mdata", bus.mem_data_o, 0);
    check_eq("rst_stall", bus.p1_stall_o, 0);
    rst_i = 1'b1;
    model_reset();
  endtask

  // Idle cycles with no request; a stray ack must have no effect.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("idle_stall", bus.p1_stall_o, 0);
      check_eq("idle_data", bus.p1_data_o, 0);
      bus.mem_ack_i = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
      bus.mem_ack_i = 1'b0;
    end
  endtask

  // One CPU access; entered and left just after a rising edge.
  task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdata);
    int unsigned set, tag, wsel, wb_la, rf_la;
    int          way, n_x, idx, en_cnt, gap, cyc;
    bit          hit, wb;
    line_t       wb_line, rf_line;
    set  = (addr >> 5) & 32'hF;
    tag  = addr >> 9;
    wsel = (addr >> 2) & 32'h7;
    bus.p1_addr_i     = addr;
    bus.p1_data_i     = wdata;
    bus.p1_MemRead_i  = rd;
    bus.p1_MemWrite_i = wr;
    bus.mem_ack_i     = 1'b0;
    #1;
    hit = 1'b0;
    way = 0;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[set][w] && m_tag[set][w] == tag) begin
        hit = 1'b1;
        way = w;
      end
    end
    if (hit) begin
      m_hits++;
      check_eq("hit_stall", bus.p1_stall_o, 0);
      if (!wr) check_eq("load_hit", bus.p1_data_o, m_line[set][way][32*wsel +: 32]);
    end else begin
      m_misses++;
      check_eq("miss_stall", bus.p1_stall_o, 1);
      check_eq("miss_data", bus.p1_data_o, 0);
      if (!m_valid[set][0])      way = 0;
      else if (!m_valid[set][1]) way = 1;
      else                       way = 1 - m_mru[set];
      wb      = m_valid[set][way] && m_dirty[set][way];
      wb_la   = (m_tag[set][way] << 9) | (set << 5);
      wb_line = m_line[set][way];
      rf_la   = (tag << 9) | (set << 5);
      if (wb) begin
        mem_model[wb_la] = wb_line;
        m_wbs++;
      end
      rf_line = mem_read(rf_la);
      n_x = wb ? 2 : 1;
      idx = 0; en_cnt = 0; gap = 0; cyc = 0;
      while (idx < n_x) begin
        @(posedge clk_i);
        #1;
        bus.mem_ack_i = 1'b0;
        cyc++;
        if (cyc > 100) begin
          check_eq("xfer_timeout", idx, n_x);
          break;
        end
        check_eq("busy_stall", bus.p1_stall_o, 1);
        if (bus.mem_enable_o) begin
          if (en_cnt == 0) begin
            if (wb && idx == 0) begin
              check_eq("wb_addr", bus.mem_addr_o, wb_la);
              check_eq("wb_write", bus.mem_write_o, 1);
              check_eq("wb_data", bus.mem_data_o, wb_line);
            end else begin
              check_eq("rf_addr", bus.mem_addr_o, rf_la);
              check_eq("rf_write", bus.mem_write_o, 0);
              if (wb) check_eq("gap_cycles", gap, 1);
            end
          end
          en_cnt++;
          if (en_cnt == int'(LAT)) begin
            bus.mem_ack_i = 1'b1;
            if (!(wb && idx == 0)) bus.mem_data_i = rf_line;
            idx++;
            en_cnt = 0;
            gap = 0;
          end
        end else begin
          gap++;
        end
      end
      @(posedge clk_i);
      #1;
      bus.mem_ack_i = 1'b0;
      #1;
      m_valid[set][way] = 1'b1;
      m_dirty[set][way] = 1'b0;
      m_tag[set][way]   = tag;
      m_line[set][way]  = rf_line;
      check_eq("post_refill_stall", bus.p1_stall_o, 0);
      check_eq("post_refill_enable", bus.mem_enable_o, 0);
      if (!wr) check_eq("refill_load", bus.p1_data_o, rf_line[32*wsel +: 32]);
    end
    m_mru[set] = way;
    if (wr) begin
      m_line[set][way][32*wsel +: 32] = wdata;
      m_dirty[set][way] = 1'b1;
    end
    @(posedge clk_i);
    #1;
    bus.p1_MemRead_i  = 1'b0;
    bus.p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    model_reset();
    do_reset();

    // Directed: cold miss, store hit, dirty eviction, read+write as store
    access(32'h0000_0040, 1, 0, 0);
    access(32'h0000_0044, 0, 1, 32'hDEAD_BEEF);
    access(32'h0000_0044, 1, 0, 0);
    access(32'h0000_0240, 1, 0, 0);
    access(32'h0000_0440, 1, 0, 0);
`ifdef DCACHE_PERF_CNT_EN
    #1;
    check_eq("perf_miss", miss_cnt, 3);
    check_eq("perf_wb", wb_cnt, 1);
    check_eq("perf_hit", hit_cnt, 2);
`endif
    access(32'h0000_0440, 1, 1, 32'h1234_5678);
    access(32'h0000_0440, 1, 0, 0);
    check_eq("rdwr_store", mem_read(32'h440) != m_line[2][0] || m_line[2][0][31:0] == 32'h1234_5678, 1);
    idle(2);

    // Reset three cycles into a refill
    do_reset();
    bus.p1_addr_i    = 32'h0000_1000;
    bus.p1_MemRead_i = 1'b1;
    #1;
    check_eq("t5_stall", bus.p1_stall_o, 1);
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    check_eq("t5_enable_before", bus.mem_enable_o, 1);
    rst_i = 1'b0;
    #1;
    check_eq("t5_enable_async", bus.mem_enable_o, 0);
    check_eq("t5_write_async", bus.mem_write_o, 0);
    check_eq("t5_addr_async", bus.mem_addr_o, 0);
    bus.p1_MemRead_i = 1'b0;
    #1;
    check_eq("t5_stall_noreq", bus.p1_stall_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();
    access(32'h0000_1000, 1, 0, 0);
    access(32'h0000_1000, 1, 0, 0);

    // Random traffic over a few sets and tags to force conflicts
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      access(a, op != 1, op != 0, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
`ifdef DCACHE_PERF_CNT_EN
    #1;
    check_eq("perf_hit_end", hit_cnt, m_hits);
    check_eq("perf_miss_end", miss_cnt, m_misses);
    check_eq("perf_wb_end", wb_cnt, m_wbs);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
